n101_pwm_deadtime: RTL and testbench

//  Dead-time/complementary output stage placed directly downstream of n101_pwm8_core.

---
 rtl/n101_pwm_dt_pkg.sv | 18 +
 rtl/n101_pwm_deadtime_if.sv | 14 +
 rtl/n101_pwm_dt_chan.sv | 75 +++++++
 rtl/n101_pwm_deadtime.sv | 93 +++++++++
 tb/tb_n101_pwm_deadtime.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/n101_pwm_dt_pkg.sv
// Shared encodings for the dead-time output stage: channel FSM states and
// register bit positions.
package n101_pwm_dt_pkg;

    localparam logic [2:0] ST_OFF  = 3'd0;
    localparam logic [2:0] ST_LOW  = 3'd1;
    localparam logic [2:0] ST_DT_R = 3'd2;
    localparam logic [2:0] ST_HIGH = 3'd3;
    localparam logic [2:0] ST_DT_F = 3'd4;

    localparam int CFG_EN_LSB     = 0;
    localparam int CFG_HI_POL_LSB = 8;
    localparam int CFG_LO_POL_LSB = 16;
    localparam int CFG_FCLR_BIT   = 31;
    localparam int DT_RISE_LSB    = 0;
    localparam int DT_FALL_LSB    = 16;

endpackage

// File: rtl/n101_pwm_deadtime_if.sv
// Register access bundle (cfg and dead-time write strobes, data and readback).
interface n101_pwm_deadtime_if;
    logic        cfg_wvalid;
    logic [31:0] cfg_wbits;
    logic [31:0] cfg_read;
    logic        dt_wvalid;
    logic [31:0] dt_wbits;
    logic [31:0] dt_read;

    modport master (output cfg_wvalid, cfg_wbits, dt_wvalid, dt_wbits,
                    input  cfg_read, dt_read);
    modport slave  (input  cfg_wvalid, cfg_wbits, dt_wvalid, dt_wbits,
                    output cfg_read, dt_read);
endinterface

// File: rtl/n101_pwm_dt_chan.sv
// One complementary channel: OFF/LOW/DT_R/HIGH/DT_F FSM, dead-time counter and
// output flops with polarity applied.
module n101_pwm_dt_chan
    import n101_pwm_dt_pkg::*;
#(
    parameter int DTW = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           en,
    input  logic           fault,
    input  logic           pwm_in,
    input  logic [DTW-1:0] dt_rise,
    input  logic [DTW-1:0] dt_fall,
    input  logic           hi_pol,
    input  logic           lo_pol,
    output logic           pwm_hi,
    output logic           pwm_lo
);

    logic [2:0]     state, state_nx;
    logic [DTW-1:0] cnt, cnt_nx;

    // Counter holds remaining cycles minus one, so DT state lasts exactly dt edges.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!en || fault) begin
            state_nx = ST_OFF;
        end else begin
            case (state)
                ST_OFF:  state_nx = ST_LOW;
                ST_LOW:  if (pwm_in) begin
                             if (dt_rise == '0) begin
                                 state_nx = ST_HIGH;
                             end else begin
                                 state_nx = ST_DT_R;
                                 cnt_nx   = dt_rise - DTW'(1);
                             end
                         end
                ST_DT_R: if (!pwm_in)        state_nx = ST_LOW;
                         else if (cnt == '0) state_nx = ST_HIGH;
                         else                cnt_nx   = cnt - DTW'(1);
                ST_HIGH: if (!pwm_in) begin
                             if (dt_fall == '0) begin
                                 state_nx = ST_LOW;
                             end else begin
                                 state_nx = ST_DT_F;
                                 cnt_nx   = dt_fall - DTW'(1);
                             end
                         end
                ST_DT_F: if (pwm_in)         state_nx = ST_HIGH;
                         else if (cnt == '0) state_nx = ST_LOW;
                         else                cnt_nx   = cnt - DTW'(1);
                default: state_nx = ST_OFF;
            endcase
        end
    end

    // Outputs decode the next state so the departing side drops on the sampling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_OFF;
            cnt    <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            pwm_hi <= (state_nx == ST_HIGH) ^ hi_pol;
            pwm_lo <= (state_nx == ST_LOW) ^ lo_pol;
        end
    end

endmodule

// File: rtl/n101_pwm_deadtime.sv
// Dead-time complementary output stage: registers, fault latch, readback, channels.
// Optional fault shutdown enabled by defining N101_PWM_DT_FAULT_EN.
module n101_pwm_deadtime
    import n101_pwm_dt_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DTW = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NCH-1:0]           pwm_in,
    input  logic                     fault_in,
    n101_pwm_deadtime_if.slave       regs,
    output logic [NCH-1:0]           pwm_hi,
    output logic [NCH-1:0]           pwm_lo,
    output logic                     fault_ip
);

    logic [NCH-1:0] en, hi_pol, lo_pol;
    logic [DTW-1:0] dt_rise, dt_fall;
    logic           fault_latch;
    logic           unused_bits;

    assign unused_bits = ^{regs.cfg_wbits, regs.dt_wbits, fault_in};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en      <= '0;
            hi_pol  <= '0;
            lo_pol  <= '0;
            dt_rise <= '0;
            dt_fall <= '0;
        end else begin
            if (regs.cfg_wvalid) begin
                en     <= regs.cfg_wbits[CFG_EN_LSB +: NCH];
                hi_pol <= regs.cfg_wbits[CFG_HI_POL_LSB +: NCH];
                lo_pol <= regs.cfg_wbits[CFG_LO_POL_LSB +: NCH];
            end
            if (regs.dt_wvalid) begin
                dt_rise <= regs.dt_wbits[DT_RISE_LSB +: DTW];
                dt_fall <= regs.dt_wbits[DT_FALL_LSB +: DTW];
            end
        end
    end

`ifdef N101_PWM_DT_FAULT_EN
    logic [1:0] fault_sync;

    // A live synchronized fault overrides a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_sync  <= '0;
            fault_latch <= 1'b0;
        end else begin
            fault_sync  <= {fault_sync[0], fault_in};
            fault_latch <= fault_sync[1] |
                           (fault_latch & ~(regs.cfg_wvalid & regs.cfg_wbits[CFG_FCLR_BIT]));
        end
    end
`else
    assign fault_latch = 1'b0;
`endif

    assign fault_ip = fault_latch;

    always_comb begin
        regs.cfg_read = '0;
        regs.cfg_read[CFG_EN_LSB +: NCH]     = en;
        regs.cfg_read[CFG_HI_POL_LSB +: NCH] = hi_pol;
        regs.cfg_read[CFG_LO_POL_LSB +: NCH] = lo_pol;
        regs.cfg_read[CFG_FCLR_BIT]          = fault_latch;
        regs.dt_read = '0;
        regs.dt_read[DT_RISE_LSB +: DTW]     = dt_rise;
        regs.dt_read[DT_FALL_LSB +: DTW]     = dt_fall;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        n101_pwm_dt_chan #(.DTW(DTW)) u_chan (
            .clock   (clock),
            .reset   (reset),
            .en      (en[i]),
            .fault   (fault_latch),
            .pwm_in  (pwm_in[i]),
            .dt_rise (dt_rise),
            .dt_fall (dt_fall),
            .hi_pol  (hi_pol[i]),
            .lo_pol  (lo_pol[i]),
            .pwm_hi  (pwm_hi[i]),
            .pwm_lo  (pwm_lo[i])
        );
    end

endmodule

// File: tb/tb_n101_pwm_deadtime.sv
// Directed bench for n101_pwm_deadtime: dead-time timing, pulse swallow,
// zero dead-time, disable, polarity and fault latch behaviour.
module tb_n101_pwm_deadtime;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] pwm_in;
    logic       fault_in;
    logic [3:0] pwm_hi, pwm_lo;
    logic       fault_ip;
    int         errors = 0;
    int         checks = 0;

    n101_pwm_deadtime_if regs ();

    n101_pwm_deadtime #(.NCH(4), .DTW(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .pwm_in   (pwm_in),
        .fault_in (fault_in),
        .regs     (regs.slave),
        .pwm_hi   (pwm_hi),
        .pwm_lo   (pwm_lo),
        .fault_ip (fault_ip)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_cfg(input logic [31:0] v);
        regs.cfg_wvalid = 1'b1;
        regs.cfg_wbits  = v;
        tick();
        regs.cfg_wvalid = 1'b0;
    endtask

    task automatic wr_dt(input logic [31:0] v);
        regs.dt_wvalid = 1'b1;
        regs.dt_wbits  = v;
        tick();
        regs.dt_wvalid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pwm_in = '0;
        fault_in = 1'b0;
        regs.cfg_wvalid = 1'b0;
        regs.cfg_wbits  = '0;
        regs.dt_wvalid  = 1'b0;
        regs.dt_wbits   = '0;
        tick();
        tick();
        check("rst_hi", 32'(pwm_hi), 32'h0);
        check("rst_lo", 32'(pwm_lo), 32'h0);
        check("rst_fip", 32'(fault_ip), 32'h0);
        check("rst_cfg", regs.cfg_read, 32'h0);
        check("rst_dt", regs.dt_read, 32'h0);
        #2 reset = 1'b0;
        tick();

        // Unused register bits read back as zero
        wr_dt(32'hABCD_1203);
        check("dt_unused", regs.dt_read, 32'h00CD_0003);

        // Test 1: dt_rise=3, dt_fall=2 on channel 0
        wr_dt(32'h0002_0003);
        check("dt_rd", regs.dt_read, 32'h0002_0003);
        wr_cfg(32'h0000_0001);
        tick();
        check("t1_low_lo", 32'(pwm_lo), 32'h1);
        check("t1_low_hi", 32'(pwm_hi), 32'h0);
        pwm_in[0] = 1'b1;
        tick();
        check("t1_n0", 32'({pwm_hi[0], pwm_lo[0]}), 32'h0);
        tick();
        check("t1_n1", 32'({pwm_hi[0], pwm_lo[0]}), 32'h0);
        tick();
        check("t1_n2", 32'({pwm_hi[0], pwm_lo[0]}), 32'h0);
        tick();
        check("t1_n3", 32'({pwm_hi[0], pwm_lo[0]}), 32'h2);
        pwm_in[0] = 1'b0;
        tick();
        check("t1_f0", 32'({pwm_hi[0], pwm_lo[0]}), 32'h0);
        tick();
        check("t1_f1", 32'({pwm_hi[0], pwm_lo[0]}), 32'h0);
        tick();
        check("t1_f2", 32'({pwm_hi[0], pwm_lo[0]}), 32'h1);

        // Test 2: dt_rise=4, 2-cycle pulse on channel 1 is swallowed
        regs.dt_wvalid = 1'b1;
        regs.dt_wbits  = 32'h0002_0004;
        wr_cfg(32'h0000_0003);
        regs.dt_wvalid = 1'b0;
        tick();
        check("t2_low", 32'(pwm_lo), 32'h3);
        pwm_in[1] = 1'b1;
        tick();
        check("t2_n0_lo", 32'(pwm_lo), 32'h1);
        check("t2_n0_hi", 32'(pwm_hi), 32'h0);
        tick();
        check("t2_n1_lo", 32'(pwm_lo), 32'h1);
        check("t2_n1_hi", 32'(pwm_hi), 32'h0);
        pwm_in[1] = 1'b0;
        tick();
        check("t2_n2_lo", 32'(pwm_lo), 32'h3);
        check("t2_n2_hi", 32'(pwm_hi), 32'h0);
        tick();
        check("t2_n3_hi", 32'(pwm_hi), 32'h0);

        // Test 3: zero dead-time, channel 2 swaps on the sampling edge
        regs.dt_wvalid = 1'b1;
        regs.dt_wbits  = 32'h0;
        wr_cfg(32'h0000_0007);
        regs.dt_wvalid = 1'b0;
        tick();
        check("t3_low", 32'(pwm_lo), 32'h7);
        for (int i = 0; i < 3; i++) begin
            pwm_in[2] = 1'b1;
            tick();
            check("t3_rise_hi", 32'(pwm_hi), 32'h4);
            check("t3_rise_lo", 32'(pwm_lo), 32'h3);
            pwm_in[2] = 1'b0;
            tick();
            check("t3_fall_hi", 32'(pwm_hi), 32'h0);
            check("t3_fall_lo", 32'(pwm_lo), 32'h7);
        end

        // Test 4: disable channel 0 while HIGH, then re-enable
        pwm_in[0] = 1'b1;
        tick();
        check("t4_high", 32'({pwm_hi[0], pwm_lo[0]}), 32'h2);
        wr_cfg(32'h0000_0006);
        check("t4_w_edge", 32'({pwm_hi[0], pwm_lo[0]}), 32'h2);
        tick();
        check("t4_off", 32'({pwm_hi[0], pwm_lo[0]}), 32'h0);
        wr_cfg(32'h0000_0007);
        tick();
        check("t4_reen_low", 32'({pwm_hi[0], pwm_lo[0]}), 32'h1);
        tick();
        check("t4_reen_high", 32'({pwm_hi[0], pwm_lo[0]}), 32'h2);
        pwm_in[0] = 1'b0;
        tick();
        check("t4_back_low", 32'({pwm_hi[0], pwm_lo[0]}), 32'h1);

        // Test 5: inverted polarity on disabled channel 3, then enable
        wr_cfg(32'h0008_0807);
        check("t5_cfg_rd", regs.cfg_read, 32'h0008_0807);
        tick();
        check("t5_off_hi", 32'(pwm_hi), 32'h8);
        check("t5_off_lo", 32'(pwm_lo), 32'hF);
        wr_cfg(32'h0008_080F);
        tick();
        check("t5_en_hi", 32'(pwm_hi), 32'h8);
        check("t5_en_lo", 32'(pwm_lo), 32'h7);

`ifdef N101_PWM_DT_FAULT_EN
        // Test 6: one-cycle fault pulse latches and shuts every channel off
        fault_in = 1'b1;
        tick();
        fault_in = 1'b0;
        tick();
        tick();
        check("t6_fip_set", 32'(fault_ip), 32'h1);
        tick();
        check("t6_off_hi", 32'(pwm_hi), 32'h8);
        check("t6_off_lo", 32'(pwm_lo), 32'h8);
        check("t6_cfg31", 32'(regs.cfg_read[31]), 32'h1);
        fault_in = 1'b1;
        tick();
        tick();
        tick();
        wr_cfg(32'h8008_080F);
        check("t6_clr_blocked", 32'(fault_ip), 32'h1);
        fault_in = 1'b0;
        tick();
        tick();
        tick();
        check("t6_still_set", 32'(fault_ip), 32'h1);
        wr_cfg(32'h8008_080F);
        check("t6_clr", 32'(fault_ip), 32'h0);
        check("t6_cfg_rd", regs.cfg_read, 32'h0008_080F);
        tick();
        check("t6_resume_lo", 32'(pwm_lo), 32'h7);
        check("t6_resume_hi", 32'(pwm_hi), 32'h8);
`else
        // Without the fault feature, fault_in has no effect
        fault_in = 1'b1;
        tick();
        fault_in = 1'b0;
        tick();
        tick();
        tick();
        check("t6_fip_zero", 32'(fault_ip), 32'h0);
        check("t6_run_lo", 32'(pwm_lo), 32'h7);
        check("t6_run_hi", 32'(pwm_hi), 32'h8);
        wr_cfg(32'h8008_080F);
        check("t6_cfg31_zero", regs.cfg_read, 32'h0008_080F);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
